data_mem_ctrl: RTL



---
 rtl/dmem_pkg.sv | 28 ++
 rtl/data_mem_ctrl_if.sv | 24 ++
 rtl/dmem_ram.sv | 33 +++
 rtl/data_mem_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: access sizes, FSM states,
// default depth and byte-lane enable generation.
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int DEF_DEPTH_WORDS = 1024;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Lane enables from the low size bits; unsigned variants share the signed pattern.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
    case (size[1:0])
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Pipeline <-> data memory request/response bundle; the pipeline is the master.
interface data_mem_ctrl_if;

  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [2:0]  size_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        stall_o;
  logic        misaligned_o;

  modport master (
    output addr_i, wdata_i, size_i, MemRead_i, MemWrite_i,
    input  rdata_o, rvalid_o, stall_o, misaligned_o
  );

  modport slave (
    input  addr_i, wdata_i, size_i, MemRead_i, MemWrite_i,
    output rdata_o, rvalid_o, stall_o, misaligned_o
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Read data appears the cycle after re; contents are never cleared by reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic                           CLK,
  input  logic                           nRESET,
  input  logic                           we,
  input  logic                           re,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET)  rdata <= '0;
    else if (re)  rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage load/store responder: stalls WAIT_STATES+1 cycles, then one RESP cycle
// with extended load data; misaligned requests are rejected in a single cycle.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_STATES = 2
) (
  input  logic            CLK,
  input  logic            nRESET,
  data_mem_ctrl_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [31:0] addr, wdata, ram_wdata, ram_q, ext;
  logic [2:0]  size, ld_size;
  logic [1:0]  ld_lane;
  logic        req, is_load, mis, oor, commit;
  logic        stall, rvalid, mis_pulse;
  logic        ld_oor, resp_ld;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign addr    = bus.addr_i;
  assign wdata   = bus.wdata_i;
  assign size    = bus.size_i;
  assign req     = bus.MemRead_i | bus.MemWrite_i;
  assign is_load = bus.MemRead_i & ~bus.MemWrite_i;
  assign mis     = req & ((((size == SZ_H) || (size == SZ_HU)) && addr[0]) ||
                          ((size == SZ_W) && (addr[1:0] != 2'b00)));
  assign oor     = {2'b00, addr[31:2]} >= 32'(DEPTH_WORDS);

  always_comb begin
    case (size[1:0])
      2'b00:   ram_wdata = {4{wdata[7:0]}};
      2'b01:   ram_wdata = {2{wdata[15:0]}};
      default: ram_wdata = wdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    stall     = 1'b0;
    rvalid    = 1'b0;
    mis_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (mis) begin
          mis_pulse = 1'b1;
        end else if (req) begin
          stall   = 1'b1;
          cnt_nxt = 3'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            commit    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall   = 1'b1;
        cnt_nxt = cnt - 3'd1;
        // Counter hits zero at this cycle's closing edge, which is the commit edge.
        if (cnt <= 3'd1) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rvalid    = resp_ld;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      resp_ld <= 1'b0;
      ld_size <= '0;
      ld_lane <= '0;
      ld_oor  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (commit) begin
        resp_ld <= is_load;
        if (is_load) begin
          ld_size <= size;
          ld_lane <= addr[1:0];
          ld_oor  <= oor;
        end
      end
    end
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .CLK    (CLK),
    .nRESET (nRESET),
    .we     (commit & nRESET & bus.MemWrite_i & ~oor),
    .re     (commit & nRESET & is_load),
    .be     (byte_en(size, addr[1:0])),
    .addr   (addr[AW+1:2]),
    .wdata  (ram_wdata),
    .rdata  (ram_q)
  );

  // Extension works purely from registered state, so rdata_o holds between loads.
  always_comb begin
    byte_sel = ram_q[{ld_lane, 3'b000} +: 8];
    half_sel = ld_lane[1] ? ram_q[31:16] : ram_q[15:0];
    case (ld_size)
      SZ_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   ext = {24'h0, byte_sel};
      SZ_H:    ext = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   ext = {16'h0, half_sel};
      default: ext = ram_q;
    endcase
    if (ld_oor) ext = '0;
  end

  assign bus.rdata_o      = ext;
  assign bus.rvalid_o     = rvalid;
  assign bus.stall_o      = stall;
  assign bus.misaligned_o = mis_pulse;

endmodule
